// File: rtl/iob_ibex_bus_arb_pkg.sv
// Shared types and constants for the Ibex instruction/data bus arbiter.
package iob_ibex_bus_arb_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    localparam logic [3:0] INSTR_BE = 4'hF;

endpackage

// File: rtl/iob_ibex_bus_arb_fifo.sv
// Route FIFO: remembers which source owns each outstanding memory transaction.
module iob_ibex_bus_arb_fifo
    import iob_ibex_bus_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_i,
    input  logic cke_i,
    input  logic rst_i,
    input  logic push_i,
    input  src_e din_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output src_e head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] slots_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = src_e'(slots_q[rd_ptr_q]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slots_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (cke_i) begin
            if (do_push) begin
                slots_q[wr_ptr_q] <= din_i;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/iob_ibex_bus_arb.sv
// Round-robin arbiter merging Ibex instruction and data ports onto one memory bus,
// routing in-order responses back through a small source FIFO.
module iob_ibex_bus_arb
    import iob_ibex_bus_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,

    input  logic              instr_req_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [DATA_W-1:0] instr_rdata_o,
    output logic              instr_err_o,

    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_err_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_err_i,

    output logic              spurious_o
);

    src_e last_src_q;
    src_e lock_src_q;
    logic lock_q;
    src_e sel;
    logic sel_req;
    logic grant;
    logic fifo_full;
    logic fifo_empty;
    src_e fifo_head;
    logic resp_valid;

    always_comb begin
        sel = SRC_INSTR;
        if (lock_q) begin
            sel = lock_src_q;
        end else if (instr_req_i && data_req_i) begin
            sel = (last_src_q == SRC_DATA) ? SRC_INSTR : SRC_DATA;
        end else if (data_req_i) begin
            sel = SRC_DATA;
        end
    end

    assign sel_req   = (sel == SRC_DATA) ? data_req_i : instr_req_i;
    assign mem_req_o = sel_req & ~fifo_full & cke_i & ~arst_i;
    assign grant     = mem_req_o & mem_gnt_i;

    assign instr_gnt_o = grant & (sel == SRC_INSTR);
    assign data_gnt_o  = grant & (sel == SRC_DATA);

    assign mem_we_o    = (sel == SRC_DATA) ? data_we_i    : 1'b0;
    assign mem_be_o    = (sel == SRC_DATA) ? data_be_i    : INSTR_BE;
    assign mem_addr_o  = (sel == SRC_DATA) ? data_addr_i  : instr_addr_i;
    assign mem_wdata_o = (sel == SRC_DATA) ? data_wdata_i : '0;

    assign resp_valid     = mem_rvalid_i & ~fifo_empty & ~arst_i;
    assign instr_rvalid_o = resp_valid & (fifo_head == SRC_INSTR);
    assign data_rvalid_o  = resp_valid & (fifo_head == SRC_DATA);
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    iob_ibex_bus_arb_fifo #(
        .DEPTH(MAX_OUT)
    ) u_route_fifo (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .rst_i  (arst_i),
        .push_i (grant),
        .din_i  (sel),
        .pop_i  (resp_valid),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .head_o (fifo_head)
    );

    // A stalled request keeps its selection frozen until the memory grants it.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            last_src_q <= SRC_DATA;
            lock_src_q <= SRC_INSTR;
            lock_q     <= 1'b0;
            spurious_o <= 1'b0;
        end else if (cke_i) begin
            if (grant) begin
                last_src_q <= sel;
                lock_q     <= 1'b0;
            end else if (mem_req_o) begin
                lock_q     <= 1'b1;
                lock_src_q <= sel;
            end
            spurious_o <= mem_rvalid_i & fifo_empty;
        end
    end

endmodule
